dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory (ce/we/addr/d/q interface, 1-cycle sync read)
//  between two requesters: port A = riscv_kernel load/store path, port B = loader/debug
//  master. Grant is same-cycle, read data returns one cycle later. Round-robin or
//  A-priority on conflict, B lock bursts, and a starvation guard. Sits between kernel and dmem.
// PARAMETERS
//  DW           32  data width
//  AW           5   address width (dmem word address)
//  PRIO_A       0   0 = round-robin on conflict; 1 = A wins every conflict
//  MAX_LOCK     8   max consecutive B beats under b_lock (1..255)
//  STARVE_LIMIT 4   loser-wait cycles before forced grant (1..255)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   asynchronous reset, active-high
//  a_req/b_req   in   1   access request; held until x_gnt seen high
//  a_we/b_we     in   1   1 = write, 0 = read
//  a_addr/b_addr in   AW  word address
//  a_wdata/b_wdata in DW  write data
//  b_lock        in   1   B asks to keep ownership for following beats
//  a_gnt/b_gnt   out  1   combinational grant; access happens this cycle
//  a_rvalid/b_rvalid out 1 read data valid (cycle after granted read)
//  a_rdata/b_rdata out DW = mem_q0 (valid only with x_rvalid)
//  mem_address0  out  AW  to dmem address0
//  mem_ce0       out  1   = a_gnt | b_gnt
//  mem_we0       out  1   winner's we, gated by grant
//  mem_d0        out  DW  winner's wdata
//  mem_q0        in   DW  dmem read data, valid cycle after ce0 & ~we0
// BEHAVIOUR
//  - Reset: all gnt/rvalid/ce/we 0, address/d/rdata 0; state IDLE; last_winner=B; counters 0.
//  - At most one gnt per cycle. Mux outputs driven from winner; no winner -> ce0=we0=0, addr/d hold 0.
//  - States: IDLE, LOCK_B. IDLE: single req wins. Conflict: PRIO_A=1 -> A; PRIO_A=0 -> not last_winner.
//    Starve guard overrides: loser waited >= STARVE_LIMIT consecutive req cycles -> loser wins.
//  - IDLE->LOCK_B when B granted with b_lock=1; lock_cnt=1.
//  - LOCK_B: B exclusive (A stalled, starve counter for A still counts but not applied);
//    each granted B beat lock_cnt++. Exit to IDLE when b_lock=0 at cycle start, or lock_cnt
//    reaches MAX_LOCK; in the exit cycle's next arbitration A wins if requesting (last_winner=B).
//    b_req=0 while b_lock=1 in LOCK_B: no grant, stay (lock_cnt unchanged).
//  - rvalid: registered; x_rvalid(t+1) = x_gnt(t) & ~x_we(t). Writes produce no rvalid.
//  - Back-to-back: new grant allowed in same cycle rvalid of prior read is high.
//  - Wait counters saturate at STARVE_LIMIT; cleared when that port is granted or drops req.
//  - Reset mid-operation: pending rvalid dropped, lock released, state IDLE immediately.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs stat_a_gnt[31:0], stat_b_gnt[31:0],
//    stat_conflict[31:0] (cycles with a_req&b_req), wrapping counters, cleared by rst and
//    by input stat_clr (1-cycle pulse, clr wins over same-cycle increment).
//  Not defined: those ports and counters absent; arbitration identical.
// TESTING
//  1 Only A reads addr 3 (ram[3]=4): a_gnt same cycle, mem_ce0=1 we0=0 addr=3; next cycle a_rvalid=1 a_rdata=4.
//  2 PRIO_A=0, A and B both req every cycle from reset: grants alternate A,B,A,B; stat_conflict=cycles.
//  3 PRIO_A=1, STARVE_LIMIT=4, both req continuously: A,A,A,A,B,A,A,A,A,B pattern.
//  4 B writes addr 0..9 with b_lock=1, MAX_LOCK=8, A requesting: 8 B grants, then A granted, B resumes.
//  5 B write 0xFFFFFF00 to addr 0 then A read addr 0: a_rdata=0xFFFFFF00, no b_rvalid.
//  6 rst pulsed during LOCK_B with pending read: all gnt/rvalid 0 during rst, next req arbitrates from IDLE, A first.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single-port data memory (1-cycle synchronous read) between the kernel
// load/store path (port A) and the loader/debug master (port B). Grants are combinational
// and the access happens in the grant cycle. Read data returns one cycle later.
// Conflicts resolve round-robin or A-first (PRIO_A). B may lock bursts of up to MAX_LOCK
// beats. A starvation guard hands the memory to a loser after STARVE_LIMIT lost cycles.
// Optional feature: define DMEM_ARB_STATS_EN to add grant/conflict statistics counters.
module dmem_port_arbiter #(
   parameter int unsigned DW           = 32,
   parameter int unsigned AW           = 5,
   parameter int unsigned PRIO_A       = 0,
   parameter int unsigned MAX_LOCK     = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   input  logic          b_lock,
   output logic          a_gnt,
   output logic          b_gnt,
   output logic          a_rvalid,
   output logic          b_rvalid,
   output logic [DW-1:0] a_rdata,
   output logic [DW-1:0] b_rdata,
`ifdef DMEM_ARB_STATS_EN
   input  logic          stat_clr,
   output logic [31:0]   stat_a_gnt,
   output logic [31:0]   stat_b_gnt,
   output logic [31:0]   stat_conflict,
`endif
   output logic [AW-1:0] mem_address0,
   output logic          mem_ce0,
   output logic          mem_we0,
   output logic [DW-1:0] mem_d0,
   input  logic [DW-1:0] mem_q0
);

   typedef enum logic {StIdle, StLockB} state_e;

   localparam logic [7:0] MaxLock    = 8'(MAX_LOCK);
   localparam logic [7:0] StarveLim  = 8'(STARVE_LIMIT);

   state_e     state_q, state_d;
   logic       last_b_q, last_b_d;     // 1: B was the most recent winner
   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic [7:0] wait_a_q, wait_a_d;
   logic [7:0] wait_b_q, wait_b_d;
   logic       a_rvalid_q, b_rvalid_q;

   logic       lock_exit;
   logic       arb_open;
   logic       a_first;
   logic       a_win, b_win;

   // State register: FSM, fairness bookkeeping and read-valid pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         last_b_q   <= 1'b1;
         lock_cnt_q <= '0;
         wait_a_q   <= '0;
         wait_b_q   <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_b_q   <= last_b_d;
         lock_cnt_q <= lock_cnt_d;
         wait_a_q   <= wait_a_d;
         wait_b_q   <= wait_b_d;
         a_rvalid_q <= a_win & ~a_we;
         b_rvalid_q <= b_win & ~b_we;
      end
   end

   // Next state: lock entry/exit, burst beat count, last winner and saturating wait counters.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      last_b_d   = last_b_q;
      if (a_win) begin
         last_b_d = 1'b0;
      end else if (b_win) begin
         last_b_d = 1'b1;
      end
      if (arb_open) begin
         // An exit cycle arbitrates like idle, so a locked B grant here starts a fresh burst.
         if (b_win && b_lock) begin
            state_d    = StLockB;
            lock_cnt_d = 8'd1;
         end else begin
            state_d    = StIdle;
            lock_cnt_d = '0;
         end
      end else if (b_win) begin
         lock_cnt_d = lock_cnt_q + 8'd1;
      end
      if (a_win || !a_req) begin
         wait_a_d = '0;
      end else if (wait_a_q >= StarveLim) begin
         wait_a_d = wait_a_q;
      end else begin
         wait_a_d = wait_a_q + 8'd1;
      end
      if (b_win || !b_req) begin
         wait_b_d = '0;
      end else if (wait_b_q >= StarveLim) begin
         wait_b_d = wait_b_q;
      end else begin
         wait_b_d = wait_b_q + 8'd1;
      end
   end

   // Outputs: arbitration decision, memory port mux and read-data return.
   always_comb begin
      lock_exit = (state_q == StLockB) && (!b_lock || (lock_cnt_q >= MaxLock));
      arb_open  = (state_q == StIdle) || lock_exit;
      // Conflict preference; in an exit cycle last_b_q is always set, so A goes first.
      a_first   = (PRIO_A != 0) || last_b_q;
      if (a_first && (wait_b_q >= StarveLim)) begin
         a_first = 1'b0;
      end else if (!a_first && (wait_a_q >= StarveLim)) begin
         a_first = 1'b1;
      end
      a_win = 1'b0;
      b_win = 1'b0;
      if (!rst) begin
         if (!arb_open) begin
            b_win = b_req;
         end else if (a_req && b_req) begin
            a_win = a_first;
            b_win = !a_first;
         end else begin
            a_win = a_req;
            b_win = b_req;
         end
      end
      a_gnt        = a_win;
      b_gnt        = b_win;
      mem_ce0      = a_win | b_win;
      mem_we0      = 1'b0;
      mem_address0 = '0;
      mem_d0       = '0;
      if (a_win) begin
         mem_we0      = a_we;
         mem_address0 = a_addr;
         mem_d0       = a_wdata;
      end else if (b_win) begin
         mem_we0      = b_we;
         mem_address0 = b_addr;
         mem_d0       = b_wdata;
      end
      a_rvalid = a_rvalid_q;
      b_rvalid = b_rvalid_q;
      a_rdata  = a_rvalid_q ? mem_q0 : '0;
      b_rdata  = b_rvalid_q ? mem_q0 : '0;
   end

`ifdef DMEM_ARB_STATS_EN
   // Statistics: wrapping grant and conflict counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_a_gnt    <= '0;
         stat_b_gnt    <= '0;
         stat_conflict <= '0;
      end else if (stat_clr) begin
         stat_a_gnt    <= '0;
         stat_b_gnt    <= '0;
         stat_conflict <= '0;
      end else begin
         if (a_win) begin
            stat_a_gnt <= stat_a_gnt + 32'd1;
         end
         if (b_win) begin
            stat_b_gnt <= stat_b_gnt + 32'd1;
         end
         if (a_req && b_req) begin
            stat_conflict <= stat_conflict + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a round-robin instance and an A-priority instance share one
// stimulus stream, each with its own RAM, and are compared every cycle against a
// cycle-level reference model. Directed scenarios pin known grant patterns and read data.
module tb_dmem_port_arbiter;

   localparam int DW           = 32;
   localparam int AW           = 5;
   localparam int MAX_LOCK     = 8;
   localparam int STARVE_LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_req, a_we, b_req, b_we, b_lock, stat_clr;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;

   logic [1:0]    a_gnt, b_gnt, a_rvalid, b_rvalid, ce, we;
   logic [DW-1:0] a_rdata [2];
   logic [DW-1:0] b_rdata [2];
   logic [DW-1:0] d [2];
   logic [DW-1:0] q [2];
   logic [AW-1:0] addr [2];
   logic [31:0]   ram [2][32];
`ifdef DMEM_ARB_STATS_EN
   logic [31:0]   st_a [2];
   logic [31:0]   st_b [2];
   logic [31:0]   st_c [2];
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state, one slot per instance (index 1 is the A-priority instance).
   bit          m_lock [2];
   int          m_cnt  [2];
   int          m_last [2];   // 1 = A won last, 2 = B won last
   int          m_wa   [2];
   int          m_wb   [2];
   bit          m_pa   [2];
   bit          m_pb   [2];
   logic [31:0] m_pda  [2];
   logic [31:0] m_pdb  [2];
   logic [31:0] shd    [2][32];
   int unsigned s_a [2];
   int unsigned s_b [2];
   int unsigned s_c [2];

   always #5 clk = ~clk;

   dmem_port_arbiter #(
      .DW(DW), .AW(AW), .PRIO_A(0), .MAX_LOCK(MAX_LOCK), .STARVE_LIMIT(STARVE_LIMIT)
   ) u_rr (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .a_gnt(a_gnt[0]), .b_gnt(b_gnt[0]), .a_rvalid(a_rvalid[0]), .b_rvalid(b_rvalid[0]),
      .a_rdata(a_rdata[0]), .b_rdata(b_rdata[0]),
`ifdef DMEM_ARB_STATS_EN
      .stat_clr(stat_clr), .stat_a_gnt(st_a[0]), .stat_b_gnt(st_b[0]),
      .stat_conflict(st_c[0]),
`endif
      .mem_address0(addr[0]), .mem_ce0(ce[0]), .mem_we0(we[0]), .mem_d0(d[0]),
      .mem_q0(q[0])
   );

   dmem_port_arbiter #(
      .DW(DW), .AW(AW), .PRIO_A(1), .MAX_LOCK(MAX_LOCK), .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pa (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .a_gnt(a_gnt[1]), .b_gnt(b_gnt[1]), .a_rvalid(a_rvalid[1]), .b_rvalid(b_rvalid[1]),
      .a_rdata(a_rdata[1]), .b_rdata(b_rdata[1]),
`ifdef DMEM_ARB_STATS_EN
      .stat_clr(stat_clr), .stat_a_gnt(st_a[1]), .stat_b_gnt(st_b[1]),
      .stat_conflict(st_c[1]),
`endif
      .mem_address0(addr[1]), .mem_ce0(ce[1]), .mem_we0(we[1]), .mem_d0(d[1]),
      .mem_q0(q[1])
   );

   // Per-instance single-port RAM, cleared while reset is held.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            for (int k = 0; k < 32; k++) ram[i][k] <= '0;
         end else if (ce[i]) begin
            if (we[i]) ram[i][addr[i]] <= d[i];
            else       q[i] <= ram[i][addr[i]];
         end
      end
   end

   task automatic chk(input int i, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL u%0d %s: got %0h expected %0h at %0t", i, name, act, exp, $time);
      end
   endtask

   // Winner under the arbitration rules: 0 none, 1 A, 2 B.
   function automatic int model_win(input int i);
      int pref;
      if (m_lock[i] && b_lock && m_cnt[i] < MAX_LOCK) return b_req ? 2 : 0;
      if (!a_req) return b_req ? 2 : 0;
      if (!b_req) return 1;
      pref = (i == 1 || m_last[i] == 2) ? 1 : 2;
      if (pref == 1 && m_wb[i] >= STARVE_LIMIT) pref = 2;
      else if (pref == 2 && m_wa[i] >= STARVE_LIMIT) pref = 1;
      return pref;
   endfunction

   task automatic check_cycle(input int i);
      int          w;
      bit          open_arb;
      logic [31:0] ea, ed;
      bit          ewe;
      if (rst) begin
         chk(i, "rst a_gnt", 32'(a_gnt[i]), 32'd0);
         chk(i, "rst b_gnt", 32'(b_gnt[i]), 32'd0);
         chk(i, "rst a_rvalid", 32'(a_rvalid[i]), 32'd0);
         chk(i, "rst b_rvalid", 32'(b_rvalid[i]), 32'd0);
         chk(i, "rst ce", 32'(ce[i]), 32'd0);
         chk(i, "rst we", 32'(we[i]), 32'd0);
         chk(i, "rst addr", 32'(addr[i]), 32'd0);
         chk(i, "rst d", d[i], 32'd0);
         chk(i, "rst a_rdata", a_rdata[i], 32'd0);
         chk(i, "rst b_rdata", b_rdata[i], 32'd0);
         m_lock[i] = 0; m_cnt[i] = 0; m_last[i] = 2; m_wa[i] = 0; m_wb[i] = 0;
         m_pa[i] = 0; m_pb[i] = 0; s_a[i] = 0; s_b[i] = 0; s_c[i] = 0;
         for (int k = 0; k < 32; k++) shd[i][k] = '0;
`ifdef DMEM_ARB_STATS_EN
         chk(i, "rst stat_conflict", st_c[i], 32'd0);
`endif
      end else begin
         w   = model_win(i);
         ea  = (w == 1) ? 32'(a_addr) : (w == 2) ? 32'(b_addr) : 32'd0;
         ed  = (w == 1) ? a_wdata : (w == 2) ? b_wdata : 32'd0;
         ewe = (w == 1) ? a_we : (w == 2) ? b_we : 1'b0;
         chk(i, "a_gnt", 32'(a_gnt[i]), 32'(w == 1));
         chk(i, "b_gnt", 32'(b_gnt[i]), 32'(w == 2));
         chk(i, "mem_ce0", 32'(ce[i]), 32'(w != 0));
         chk(i, "mem_we0", 32'(we[i]), 32'(ewe));
         chk(i, "mem_address0", 32'(addr[i]), ea);
         chk(i, "mem_d0", d[i], ed);
         chk(i, "a_rvalid", 32'(a_rvalid[i]), 32'(m_pa[i]));
         chk(i, "b_rvalid", 32'(b_rvalid[i]), 32'(m_pb[i]));
         if (m_pa[i]) chk(i, "a_rdata", a_rdata[i], m_pda[i]);
         if (m_pb[i]) chk(i, "b_rdata", b_rdata[i], m_pdb[i]);
`ifdef DMEM_ARB_STATS_EN
         chk(i, "stat_a_gnt", st_a[i], s_a[i]);
         chk(i, "stat_b_gnt", st_b[i], s_b[i]);
         chk(i, "stat_conflict", st_c[i], s_c[i]);
`endif
         open_arb = !(m_lock[i] && b_lock && m_cnt[i] < MAX_LOCK);
         if (w != 0) m_last[i] = w;
         if (open_arb) begin
            m_lock[i] = (w == 2) && b_lock;
            m_cnt[i]  = m_lock[i] ? 1 : 0;
         end else if (w == 2) begin
            m_cnt[i]++;
         end
         m_wa[i] = (w == 1 || !a_req) ? 0 : ((m_wa[i] >= STARVE_LIMIT) ? m_wa[i] : m_wa[i] + 1);
         m_wb[i] = (w == 2 || !b_req) ? 0 : ((m_wb[i] >= STARVE_LIMIT) ? m_wb[i] : m_wb[i] + 1);
         m_pa[i] = (w == 1) && !a_we;
         m_pb[i] = (w == 2) && !b_we;
         if (m_pa[i]) m_pda[i] = shd[i][a_addr];
         if (m_pb[i]) m_pdb[i] = shd[i][b_addr];
         if (w == 1 && a_we) shd[i][a_addr] = a_wdata;
         if (w == 2 && b_we) shd[i][b_addr] = b_wdata;
         if (stat_clr) begin
            s_a[i] = 0; s_b[i] = 0; s_c[i] = 0;
         end else begin
            if (w == 1) s_a[i]++;
            if (w == 2) s_b[i]++;
            if (a_req && b_req) s_c[i]++;
         end
      end
   endtask

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) check_cycle(i);
   end

   // Advance to just after the next rising edge with all requests idle.
   task automatic step();
      @(posedge clk);
      #1;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0; stat_clr = 0;
   endtask

   task automatic do_reset();
      step();
      rst = 1;
      step();
      rst = 0;
   endtask

   function automatic logic [31:0] gcode(input int i);
      return a_gnt[i] ? 32'h41 : (b_gnt[i] ? 32'h42 : 32'h2d);
   endfunction

   initial begin
      string pat;
      int    b_idx;
      bit    a_done;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0; stat_clr = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Single-requester read returns data the cycle after the grant.
      step(); b_req = 1; b_we = 1; b_addr = 5'd3; b_wdata = 32'd4;
      #3 chk(0, "t1 setup b_gnt", 32'(b_gnt[0]), 32'd1);
      step(); a_req = 1; a_addr = 5'd3;
      #3;
      for (int i = 0; i < 2; i++) begin
         chk(i, "t1 a_gnt", 32'(a_gnt[i]), 32'd1);
         chk(i, "t1 ce", 32'(ce[i]), 32'd1);
         chk(i, "t1 we", 32'(we[i]), 32'd0);
         chk(i, "t1 addr", 32'(addr[i]), 32'd3);
      end
      step();
      #3;
      for (int i = 0; i < 2; i++) begin
         chk(i, "t1 a_rvalid", 32'(a_rvalid[i]), 32'd1);
         chk(i, "t1 a_rdata", a_rdata[i], 32'd4);
      end

      // B write followed by A read of the same word.
      step(); b_req = 1; b_we = 1; b_addr = 5'd0; b_wdata = 32'hFFFF_FF00;
      step(); a_req = 1; a_addr = 5'd0;
      #3 chk(0, "t5 b_rvalid after write", 32'(b_rvalid[0]), 32'd0);
      step();
      #3;
      for (int i = 0; i < 2; i++) begin
         chk(i, "t5 a_rdata", a_rdata[i], 32'hFFFF_FF00);
         chk(i, "t5 b_rvalid", 32'(b_rvalid[i]), 32'd0);
      end

      // Continuous conflict from reset: alternation vs. A-priority with starve guard.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(); a_req = 1; b_req = 1; a_addr = 5'(k); b_addr = 5'(k + 1);
         #3;
         for (int i = 0; i < 2; i++) begin
            pat = (i == 0) ? "ABABABABAB" : "AAAABAAAAB";
            chk(i, $sformatf("t23 grant %0d", k), gcode(i), 32'(pat.getc(k)));
         end
      end
      step();
`ifdef DMEM_ARB_STATS_EN
      #3 for (int i = 0; i < 2; i++) chk(i, "t2 stat_conflict", st_c[i], 32'd10);
`endif

      // Locked B write burst with A waiting: 8 B beats, A, then B resumes.
      do_reset();
      b_idx  = 0;
      a_done = 0;
      for (int c = 0; c < 11; c++) begin
         step();
         b_req = 1; b_we = 1; b_lock = 1; b_addr = 5'(b_idx); b_wdata = 32'(100 + b_idx);
         a_req = (c >= 1) && !a_done; a_addr = 5'd1;
         #3;
         pat = "BBBBBBBBABB";
         for (int i = 0; i < 2; i++) chk(i, $sformatf("t4 grant %0d", c), gcode(i),
                                         32'(pat.getc(c)));
         if (b_gnt[0]) b_idx++;
         if (a_gnt[0]) a_done = 1;
      end

      // Reset in the middle of a locked read burst.
      do_reset();
      step(); b_req = 1; b_lock = 1; b_addr = 5'd2;
      step(); b_req = 1; b_lock = 1; b_addr = 5'd3;
      step(); b_req = 1; b_lock = 1; a_req = 1; rst = 1;
      #3;
      for (int i = 0; i < 2; i++) begin
         chk(i, "t6 a_gnt in rst", 32'(a_gnt[i]), 32'd0);
         chk(i, "t6 b_gnt in rst", 32'(b_gnt[i]), 32'd0);
         chk(i, "t6 b_rvalid in rst", 32'(b_rvalid[i]), 32'd0);
      end
      step(); rst = 0; a_req = 1; b_req = 1; b_lock = 1;
      #3;
      for (int i = 0; i < 2; i++) begin
         chk(i, "t6 a_gnt after rst", 32'(a_gnt[i]), 32'd1);
         chk(i, "t6 b_gnt after rst", 32'(b_gnt[i]), 32'd0);
      end

      // Randomized traffic checked by the per-cycle model.
      for (int c = 0; c < 3000; c++) begin
         step();
         rst      = ($urandom_range(0, 299) == 0);
         a_req    = ($urandom_range(0, 99) < 60);
         a_we     = ($urandom_range(0, 2) == 0);
         a_addr   = 5'($urandom_range(0, 7));
         a_wdata  = $urandom;
         b_req    = ($urandom_range(0, 99) < 60);
         b_we     = ($urandom_range(0, 2) == 0);
         b_addr   = 5'($urandom_range(0, 7));
         b_wdata  = $urandom;
         b_lock   = ($urandom_range(0, 9) < 6);
         stat_clr = ($urandom_range(0, 39) == 0);
      end
      step();
      rst = 0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
